// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the SRAM memory controller: FSM state encoding and default address map.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter: counts while enabled, clears on request.
// pre_tc flags the second-to-last cycle so registered strobes can release on time.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic pre_tc_o
);

  localparam int CW = $clog2(WAIT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o     = (cnt_q == CW'(WAIT_CYCLES - 1));
  assign pre_tc_o = (cnt_q == CW'(WAIT_CYCLES - 2));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit load/store into two halfword SRAM phases, freezing the pipeline
// via ready until done. All SRAM pin drivers are registered.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_t               state_q;
  logic [SRAM_AW-2:0]   word_q;
  logic [SRAM_AW-2:0]   word_d;
  logic                 is_wr_q;
  logic [15:0]          wdata_hi_q;
  logic [31:0]          read_data_q;
  logic [SRAM_AW-1:0]   sram_addr_q;
  logic [15:0]          dq_out_q;
  logic                 dq_oe_q;
  logic                 we_n_q;
  logic                 oe_n_q;
  logic                 req;
  logic                 phase_active;
  logic                 tc;
  logic                 pre_tc;

  assign req          = rd_en | wr_en;
  // Out-of-range addresses wrap silently through the modulo subtraction.
  assign word_d       = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  assign phase_active = (state_q == ST_ACC_LO) || (state_q == ST_ACC_HI);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (~phase_active | tc),
    .en_i     (phase_active),
    .tc_o     (tc),
    .pre_tc_o (pre_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      is_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q     <= ST_ACC_LO;
            word_q      <= word_d;
            is_wr_q     <= wr_en;
            wdata_hi_q  <= write_data[31:16];
            sram_addr_q <= {word_d, 1'b0};
            if (wr_en) begin
              dq_oe_q  <= 1'b1;
              dq_out_q <= write_data[15:0];
              we_n_q   <= 1'b0;
            end else begin
              oe_n_q   <= 1'b0;
            end
          end
        end
        ST_ACC_LO: begin
          // Release the write strobe one cycle early so data is held past its rising edge.
          if (is_wr_q && pre_tc) we_n_q <= 1'b1;
          if (tc) begin
            state_q     <= ST_ACC_HI;
            sram_addr_q <= {word_q, 1'b1};
            if (is_wr_q) begin
              dq_out_q <= wdata_hi_q;
              we_n_q   <= 1'b0;
            end else begin
              read_data_q[15:0] <= sram_dq_in;
            end
          end
        end
        ST_ACC_HI: begin
          if (is_wr_q && pre_tc) we_n_q <= 1'b1;
          if (tc) begin
            state_q <= ST_DONE;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            if (!is_wr_q) read_data_q[31:16] <= sram_dq_in;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Multi-cycle controller between the EXE/MEM pipeline boundary and a 16-bit-wide external SRAM.
- Takes the ALU result as a byte address plus the load/store enables, and splits each 32-bit access into two sequenced halfword accesses.
- Holds `ready` low so the pipeline freezes until the access completes.
- The only block that owns the SRAM pins.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0
WAIT_CYCLES, 3, cycles per halfword phase; legal range >= 2
SRAM_AW, 18, SRAM halfword address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  1  load request (MEM_R_EN); held stable while ready=0
wr_en  input  1  store request (MEM_W_EN); held stable while ready=0
address  input  32  byte address (ALU result)
write_data  input  32  store data (Val_Rm)
read_data  output  32  load result, registered
ready  output  1  0 = freeze pipeline; 1 = access done or no access pending
sram_addr  output  SRAM_AW  halfword address
sram_dq_out  output  16  write data to SRAM
sram_dq_in  input  16  read data from SRAM
sram_dq_oe  output  1  1 = drive sram_dq_out onto pins (top-level tristate)
sram_we_n  output  1  write strobe, active low
sram_oe_n  output  1  output enable, active low

Behaviour:
Reset and request handling:
- Reset (async, rst=1): state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Reset mid-access aborts immediately, with no completion pulse.
- req = rd_en | wr_en. If both are asserted, the access is treated as a write (rd_en ignored).
- ready = (state==IDLE & ~req) | (state==DONE). This is combinational from state and req.

Address mapping:
- off = address - BASE_ADDR, 32-bit modulo subtraction.
- word = off[SRAM_AW:2].
- Low half at {word,0}; high half at {word,1}. off[1:0] is ignored.
- No range check: out-of-range addresses wrap silently.

FSM states IDLE, ACC_LO, ACC_HI, DONE:
- IDLE: on req, latch word, op and write_data, go to ACC_LO with cnt=0. Otherwise stay in IDLE.
- ACC_LO:
  - sram_addr = {word,0}.
  - Read: oe_n=0.
  - Write: dq_oe=1, dq_out=wdata[15:0], we_n=0 for cnt 0..WAIT_CYCLES-2, we_n=1 on the last cycle (data held).
  - cnt increments each cycle. At cnt==WAIT_CYCLES-1, a read captures sram_dq_in into read_data[15:0]; then go to ACC_HI with cnt=0.
- ACC_HI: same as ACC_LO with {word,1} and wdata[31:16]. A read captures into read_data[31:16]; then go to DONE.
- DONE: all SRAM controls inactive, ready=1 for exactly one cycle, then IDLE unconditionally. A req seen in DONE is not accepted; it is evaluated next cycle in IDLE.

Timing and data:
- Latency: accept at t0, ACC_LO t1..tW, ACC_HI tW+1..t2W, DONE t2W+1, with W=WAIT_CYCLES. ready is low t0..t2W: 2W+1 cycles (7 for W=3).
- read_data holds its last load value across writes and idle.
- read_data is valid from DONE onward.
- Back-to-back requests: a new access is accepted at the earliest in the cycle after DONE, with no gap cycle beyond that.
- Request dropped mid-access (protocol violation): the access still completes on latched values.

Decomposition:
- Shared package: FSM state encoding (IDLE/ACC_LO/ACC_HI/DONE as 2-bit localparams) and default BASE_ADDR.
- One natural sub-module, sram_phase_timer: a cycle counter with clear and a terminal-count flag, reused by both access phases.
- The FSM and datapath latches stay in sram_mem_ctrl.

Test Plan:
- Reset: assert rst mid-ACC_HI of a write -> same cycle: we_n=1, dq_oe=0, read_data=0. After release: ready=1 with req=0.
- Store then load: wr_en, address=1028, write_data=0xDEADBEEF.
  - Expect sram_addr 2 then 3, dq_out 0xBEEF then 0xDEAD, we_n low 2 cycles per phase, ready low 7 cycles.
  - Then rd_en at 1028 with the SRAM model returning the stored data -> read_data=0xDEADBEEF in DONE.
- Idle pass-through: req=0 for 10 cycles -> ready=1 throughout, all SRAM strobes inactive, read_data unchanged.
- Simultaneous rd_en=wr_en=1 at address=1024, write_data=0x12345678 -> write performed at halfwords 0/1, read_data not modified.
- Back-to-back: a load held through DONE, then a different load presented the next cycle -> second access starts in IDLE one cycle after DONE; two distinct DONE pulses 8 cycles apart.
- Wrap and parameters: address=0 with BASE_ADDR=1024 -> off=0xFFFFFC00, sram_addr uses off[18:2] (word=0x1FF00). Rerun with WAIT_CYCLES=2 -> ready low exactly 5 cycles.
